axil_gesture_reg_slave: RTL and testbench

- AXI4-Lite slave (responder) register block for the gesture-recognizer IP.
- Exposes NUM_REGS 32-bit read/write registers to the PS-side AXI4-Lite master.
- Drives the register contents and per-register write strobes into the recognizer datapath.
- Handles independent AW/W arrival, back-pressure on B/R, and SLVERR on out-of-range addresses.

---
 rtl/axil_gesture_reg_slave_if.sv | 43 ++++
 rtl/axil_gesture_reg_slave.sv | 197 +++++++++++++++++++
 tb/tb_axil_gesture_reg_slave.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_gesture_reg_slave_if.sv
// AXI4-Lite bus bundle between the PS-side master and the gesture register block.
interface axil_gesture_reg_slave_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_gesture_reg_slave.sv
// AXI4-Lite register slave for the gesture recognizer: NUM_REGS 32-bit RW
// registers, per-register write pulses, SLVERR on out-of-range word index.
// Optional byte-strobe writes are enabled by defining AXIL_GESTURE_WSTRB_EN.
module axil_gesture_reg_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  axil_gesture_reg_slave_if.slave        s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int unsigned IDX_W       = ADDR_WIDTH - 2;
  localparam int unsigned STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_ACCEPT = 1'b0, W_RESP = 1'b1} wstate_e;
  wstate_e wstate, wstate_nx;

  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  arready_q, rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs_c, w_hs_c, do_write_c, wr_in_range_c;
  logic                  aw_held_d, w_held_d;
  logic [IDX_W-1:0]      aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [STRB_W-1:0]     wstrb_d;
  logic                  awready_d, wready_d, bvalid_d;
  logic [1:0]            bresp_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_d;
  logic [NUM_REGS-1:0]   wr_pulse_d;

  logic [IDX_W-1:0]      rd_idx_c;
  logic                  rd_in_range_c;
  logic [DATA_WIDTH-1:0] rd_data_c;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign aw_hs_c = s_axi.awvalid & awready_q;
  assign w_hs_c  = s_axi.wvalid & wready_q;

  // AW/W capture: this cycle's handshakes merged with anything already held
  always_comb begin
    aw_held_d = aw_held;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (wstate == W_RESP && s_axi.bready) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (aw_hs_c) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs_c) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end
  end

  assign do_write_c    = (wstate == W_ACCEPT) && aw_held_d && w_held_d;
  assign wr_in_range_c = 32'(aw_idx_d) < NUM_REGS;

  // Write FSM state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wstate <= W_ACCEPT;
    else                wstate <= wstate_nx;
  end

  // Write FSM next state: one write outstanding until B is accepted
  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      W_ACCEPT: if (do_write_c) wstate_nx = W_RESP;
      W_RESP:   if (s_axi.bready) wstate_nx = W_ACCEPT;
      default:  wstate_nx = W_ACCEPT;
    endcase
  end

  // Write FSM outputs and register update, registered on the next edge
  always_comb begin
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    bvalid_d   = 1'b0;
    bresp_d    = bresp_q;
    reg_q_d    = reg_q;
    wr_pulse_d = '0;
    if (wstate_nx == W_ACCEPT) begin
      awready_d = !aw_held_d;
      wready_d  = !w_held_d;
    end else begin
      bvalid_d = 1'b1;
    end
    if (do_write_c) begin
      bresp_d = wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_in_range_c && aw_idx_d == IDX_W'(i)) begin
          wr_pulse_d[i] = 1'b1;
`ifdef AXIL_GESTURE_WSTRB_EN
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wstrb_d[b]) reg_q_d[i*DATA_WIDTH + b*8 +: 8] = wdata_d[b*8 +: 8];
          end
`else
          reg_q_d[i*DATA_WIDTH +: DATA_WIDTH] = wdata_d;
`endif
        end
      end
    end
  end

  // Write-side holding registers, bus outputs and register file
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      reg_q        <= '0;
      reg_wr_pulse <= '0;
    end else begin
      aw_held      <= aw_held_d;
      w_held       <= w_held_d;
      aw_idx_q     <= aw_idx_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      reg_q        <= reg_q_d;
      reg_wr_pulse <= wr_pulse_d;
    end
  end

  // Read decode from the current register contents (pre-write on a collision)
  always_comb begin
    rd_idx_c      = s_axi.araddr[ADDR_WIDTH-1:2];
    rd_in_range_c = 32'(rd_idx_c) < NUM_REGS;
    rd_data_c     = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_in_range_c && rd_idx_c == IDX_W'(i)) rd_data_c = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read channel: one-cycle latency, ARREADY tracks !RVALID
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (s_axi.arvalid && arready_q) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_data_c;
      rresp_q   <= rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi.rready) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else begin
      arready_q <= !rvalid_q;
    end
  end

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
`ifndef AXIL_GESTURE_WSTRB_EN
  logic unused_strb;
  assign unused_strb = &{1'b0, wstrb_d};
`endif
endmodule

// File: tb/tb_axil_gesture_reg_slave.sv
// Scoreboard bench for axil_gesture_reg_slave: directed cases plus random traffic.
`timescale 1ns/1ps
module tb_axil_gesture_reg_slave;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NR  = 4;
  localparam int          TMO = 100;

  typedef struct packed {
    logic [1:0]       resp;
    logic [NR-1:0]    pulse;
    logic [NR*DW-1:0] regs;
  } b_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    reg_wr_pulse;

  axil_gesture_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axil_gesture_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int bmode = 0;
  int rmode = 0;
  logic [DW-1:0] mem [NR];
  b_exp_t bq [$];
  r_exp_t rq [$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endfunction

  function automatic void fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no/unexpected event, expected a matching handshake", name);
  endfunction

  // Reference model: flat view of the register file
  function automatic logic [NR*DW-1:0] flat();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = mem[i];
    return r;
  endfunction

  function automatic void exp_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    b_exp_t e;
    int idx;
    idx = int'(addr) / 4;
    if (idx < NR) begin
`ifdef AXIL_GESTURE_WSTRB_EN
      for (int b = 0; b < 4; b++) if (strb[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
`else
      mem[idx] = data;
`endif
      e.resp  = 2'b00;
      e.pulse = NR'(1 << idx);
    end else begin
      e.resp  = 2'b10;
      e.pulse = '0;
    end
    e.regs = flat();
    bq.push_back(e);
  endfunction

  function automatic void exp_read(input logic [AW-1:0] addr);
    r_exp_t e;
    int idx;
    idx = int'(addr) / 4;
    if (idx < NR) begin
      e.data = mem[idx];
      e.resp = 2'b00;
    end else begin
      e.data = '0;
      e.resp = 2'b10;
    end
    rq.push_back(e);
  endfunction

  // BREADY/RREADY generators: random, forced low, or forced high
  always @(posedge clk) begin
    #1;
    case (bmode)
      0:       axi.bready = ($urandom_range(0, 3) != 0);
      1:       axi.bready = 1'b0;
      default: axi.bready = 1'b1;
    endcase
    case (rmode)
      0:       axi.rready = ($urandom_range(0, 3) != 0);
      1:       axi.rready = 1'b0;
      default: axi.rready = 1'b1;
    endcase
  end

  // Monitor: compare DUT responses against the scoreboard queues
  logic   b_prev = 1'b0;
  logic [1:0] bresp_prev = 2'b00;
  b_exp_t mon_b;
  r_exp_t mon_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_prev = 1'b0;
    end else begin
      if (axi.bvalid && !b_prev) begin
        if (bq.size() == 0) fail("b_unexpected");
        else begin
          check("wr_pulse", 128'(reg_wr_pulse), 128'(bq[0].pulse));
          check("reg_q", reg_q, bq[0].regs);
          check("b_latency", 128'(cyc), 128'(hs_cyc));
        end
      end else begin
        check("wr_pulse_idle", 128'(reg_wr_pulse), 128'(0));
      end
      if (axi.bvalid && b_prev) check("bresp_stable", 128'(axi.bresp), 128'(bresp_prev));
      if (axi.bvalid) check("aw_w_blocked", 128'({axi.awready, axi.wready}), 128'(0));
      if (axi.bvalid && axi.bready && bq.size() != 0) begin
        mon_b = bq.pop_front();
        check("bresp", 128'(axi.bresp), 128'(mon_b.resp));
      end
      if (axi.rvalid) check("arready_low", 128'(axi.arready), 128'(0));
      if (axi.rvalid && axi.rready) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          mon_r = rq.pop_front();
          check("rdata", 128'(axi.rdata), 128'(mon_r.data));
          check("rresp", 128'(axi.rresp), 128'(mon_r.resp));
        end
      end
      b_prev     = axi.bvalid;
      bresp_prev = axi.bresp;
    end
  end

  // Drive one write; AW and W start independently after their own delays
  task automatic drv_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit wait_b);
    int aw_c, w_c;
    bit aw_done, w_done, b_done;
    aw_c = 0; w_c = 0; aw_done = 0; w_done = 0; b_done = 0;
    fork
      begin
        repeat (aw_dly) @(posedge clk);
        if (aw_dly > 0) #1;
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        for (int i = 0; i < TMO && !aw_done; i++) begin
          @(negedge clk);
          if (axi.awready) begin
            @(posedge clk); #1;
            aw_done = 1'b1;
            aw_c = cyc;
          end
        end
        axi.awvalid = 1'b0;
        if (!aw_done) fail("aw_timeout");
      end
      begin
        repeat (w_dly) @(posedge clk);
        if (w_dly > 0) #1;
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        for (int i = 0; i < TMO && !w_done; i++) begin
          @(negedge clk);
          if (axi.wready) begin
            @(posedge clk); #1;
            w_done = 1'b1;
            w_c = cyc;
          end
        end
        axi.wvalid = 1'b0;
        if (!w_done) fail("w_timeout");
      end
    join
    hs_cyc = (aw_c > w_c) ? aw_c : w_c;
    if (wait_b) begin
      for (int i = 0; i < TMO && !b_done; i++) begin
        @(negedge clk);
        if (axi.bvalid && axi.bready) begin
          @(posedge clk); #1;
          b_done = 1'b1;
        end
      end
      if (!b_done) fail("b_timeout");
    end
  endtask

  task automatic drv_read(input logic [AW-1:0] addr, input bit wait_r);
    bit ar_done, r_done;
    ar_done = 0; r_done = 0;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    for (int i = 0; i < TMO && !ar_done; i++) begin
      @(negedge clk);
      if (axi.arready) begin
        @(posedge clk); #1;
        ar_done = 1'b1;
      end
    end
    axi.arvalid = 1'b0;
    if (!ar_done) fail("ar_timeout");
    if (wait_r) begin
      for (int i = 0; i < TMO && !r_done; i++) begin
        @(negedge clk);
        if (axi.rvalid && axi.rready) begin
          @(posedge clk); #1;
          r_done = 1'b1;
        end
      end
      if (!r_done) fail("r_timeout");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    s;
    bit            drained;

    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    for (int i = 0; i < NR; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 128'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 128'(0));
    check("rst_resp", 128'({axi.bresp, axi.rresp}), 128'(0));
    check("rst_rdata", 128'(axi.rdata), 128'(0));
    check("rst_reg_q", reg_q, 128'(0));
    check("rst_pulse", 128'(reg_wr_pulse), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 128'({axi.awready, axi.wready, axi.arready}), 128'(3'b111));

    // Basic write/read-back of every register
    for (int i = 0; i < NR; i++) begin
      a = AW'(4 * i);
      d = DW'(i + 1);
      exp_write(a, d, 4'hF);
      drv_write(a, d, 4'hF, 0, 0, 1'b1);
    end
    for (int i = 0; i < NR; i++) begin
      a = AW'(4 * i);
      exp_read(a);
      drv_read(a, 1'b1);
    end
    check("reg_q_basic", reg_q, 128'h00000004_00000003_00000002_00000001);

    // W arrives three cycles before AW
    exp_write(5'h08, 32'hA5A5A5A5, 4'hF);
    drv_write(5'h08, 32'hA5A5A5A5, 4'hF, 3, 0, 1'b1);
    check("reg2_w_first", 128'(reg_q[95:64]), 128'(32'hA5A5A5A5));

    // B back-pressure with a second write queued behind it
    bmode = 1;
    exp_write(5'h04, 32'h0BADF00D, 4'hF);
    drv_write(5'h04, 32'h0BADF00D, 4'hF, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("bvalid_held", 128'(axi.bvalid), 128'(1));
    exp_write(5'h0C, 32'h12345678, 4'hF);
    fork
      drv_write(5'h0C, 32'h12345678, 4'hF, 0, 0, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1 bmode = 2;
      end
    join
    bmode = 0;

    // Out-of-range write and read
    exp_write(5'h10, 32'hDEADBEEF, 4'hF);
    drv_write(5'h10, 32'hDEADBEEF, 4'hF, 1, 0, 1'b1);
    exp_read(5'h14);
    drv_read(5'h14, 1'b1);

    // Byte strobes
    exp_write(5'h00, 32'h11223344, 4'hF);
    drv_write(5'h00, 32'h11223344, 4'hF, 0, 1, 1'b1);
    exp_write(5'h00, 32'hAABBCCDD, 4'b0010);
    drv_write(5'h00, 32'hAABBCCDD, 4'b0010, 0, 0, 1'b1);
`ifdef AXIL_GESTURE_WSTRB_EN
    check("wstrb_merge", 128'(reg_q[31:0]), 128'(32'h1122CC44));
`else
    check("wstrb_ignored", 128'(reg_q[31:0]), 128'(32'hAABBCCDD));
`endif
    exp_write(5'h08, 32'h77777777, 4'h0);
    drv_write(5'h08, 32'h77777777, 4'h0, 0, 0, 1'b1);

    // Read and write to the same register in the same cycle
    d = $urandom;
    exp_read(5'h04);
    exp_write(5'h04, d, 4'hF);
    fork
      drv_write(5'h04, d, 4'hF, 0, 0, 1'b1);
      drv_read(5'h04, 1'b1);
    join

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      a = AW'($urandom_range(0, 31));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        exp_write(a, d, s);
        drv_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end else begin
        exp_read(a);
        drv_read(a, 1'b1);
      end
    end

    // Reset while both B and R responses are pending
    bmode = 1;
    rmode = 1;
    exp_write(5'h0C, 32'h55555555, 4'hF);
    drv_write(5'h0C, 32'h55555555, 4'hF, 0, 0, 1'b0);
    exp_read(5'h04);
    drv_read(5'h04, 1'b0);
    @(posedge clk); #1;
    check("b_r_pending", 128'({axi.bvalid, axi.rvalid}), 128'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 128'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 128'(0));
    check("mid_rst_data", 128'({axi.bresp, axi.rresp, axi.rdata}), 128'(0));
    check("mid_rst_reg_q", reg_q, 128'(0));
    bq.delete();
    rq.delete();
    for (int i = 0; i < NR; i++) mem[i] = '0;
    bmode = 0;
    rmode = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale_resp", 128'({axi.bvalid, axi.rvalid}), 128'(0));
    exp_read(5'h00);
    drv_read(5'h00, 1'b1);

    // Drain the scoreboard
    drained = 1'b0;
    for (int i = 0; i < 200 && !drained; i++) begin
      if (bq.size() == 0 && rq.size() == 0) drained = 1'b1;
      else @(posedge clk);
    end
    if (!drained) fail("drain");
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
